// File: rtl/blink_cmd_uart_rx.sv
// blink_cmd_uart_rx: UART (8N1) command receiver holding the LED blinker configuration.
// Optional BLINK_CMD_PARITY_EN: frames become 8E1 with even-parity checking.
module blink_cmd_uart_rx #(
  parameter int unsigned CLK_FREQ     = 25_000_000,
  parameter int unsigned BAUD         = 115_200,
  parameter int unsigned TIMEOUT_CLKS = CLK_FREQ / 100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        uart_rx,
  output logic [31:0] half_period,
  output logic [7:0]  led_mask,
  output logic        cmd_valid,
  output logic        cmd_err
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned CW           = $clog2(CLKS_PER_BIT + 1);
  localparam int unsigned TW           = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CW-1:0] BIT_END    = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END   = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] TMO_END    = TW'(TIMEOUT_CLKS);
  localparam logic [31:0]   HP_RST     = 32'(CLK_FREQ / 10);
  localparam logic [7:0]    MASK_RST   = 8'h01;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
`ifdef BLINK_CMD_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP,
    RX_BREAK
  } rx_state_t;

  typedef enum logic [1:0] {
    P_IDLE,
    P_PERIOD,
    P_MASK
  } p_state_t;

  logic            sync1_q, sync2_q, rx_prev_q;
  logic            rx_s;
  rx_state_t       rx_state_q, rx_state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      sh_q, sh_d;
  logic            byte_ok, rx_err;
`ifdef BLINK_CMD_PARITY_EN
  logic            par_bad_q, par_bad_d;
`endif

  p_state_t        p_state_q, p_state_d;
  logic [1:0]      idx_q, idx_d;
  logic [23:0]     acc_q, acc_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [31:0]     hp_q, hp_d;
  logic [7:0]      mask_q, mask_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;

  assign rx_s = sync2_q;

  always_comb begin
    rx_state_d = rx_state_q;
    cnt_d      = cnt_q + CW'(1);
    bit_idx_d  = bit_idx_q;
    sh_d       = sh_q;
    byte_ok    = 1'b0;
    rx_err     = 1'b0;
`ifdef BLINK_CMD_PARITY_EN
    par_bad_d  = par_bad_q;
`endif
    case (rx_state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (rx_prev_q && !rx_s) rx_state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == HALF_END) begin
          cnt_d      = '0;
          bit_idx_d  = '0;
          rx_state_d = rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == BIT_END) begin
          cnt_d     = '0;
          sh_d      = {rx_s, sh_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef BLINK_CMD_PARITY_EN
            rx_state_d = RX_PARITY;
`else
            rx_state_d = RX_STOP;
`endif
          end
        end
      end
`ifdef BLINK_CMD_PARITY_EN
      RX_PARITY: begin
        if (cnt_q == BIT_END) begin
          cnt_d      = '0;
          par_bad_d  = rx_s ^ (^sh_q);
          rx_state_d = RX_STOP;
        end
      end
`endif
      RX_STOP: begin
        if (cnt_q == BIT_END) begin
          cnt_d = '0;
          if (rx_s) begin
            rx_state_d = RX_IDLE;
`ifdef BLINK_CMD_PARITY_EN
            // parity failure is reported at the stop sample so a bad stop bit can't double-pulse
            if (par_bad_q) rx_err = 1'b1;
            else           byte_ok = 1'b1;
`else
            byte_ok = 1'b1;
`endif
          end else begin
            rx_err     = 1'b1;
            rx_state_d = RX_BREAK;
          end
        end
      end
      RX_BREAK: begin
        cnt_d = '0;
        if (rx_s) rx_state_d = RX_IDLE;
      end
      default: begin
        cnt_d      = '0;
        rx_state_d = RX_IDLE;
      end
    endcase
  end

  always_comb begin
    p_state_d = p_state_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    hp_d      = hp_q;
    mask_d    = mask_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    tmo_d     = (p_state_q != P_IDLE) ? tmo_q + TW'(1) : '0;
    if (byte_ok) begin
      tmo_d = '0;
      case (p_state_q)
        P_IDLE: begin
          case (sh_q)
            8'h50: begin
              p_state_d = P_PERIOD;
              idx_d     = '0;
            end
            8'h4D: p_state_d = P_MASK;
            8'h52: begin
              hp_d    = HP_RST;
              mask_d  = MASK_RST;
              valid_d = 1'b1;
            end
            default: ;
          endcase
        end
        P_PERIOD: begin
          if (idx_q == 2'd3) begin
            p_state_d = P_IDLE;
            if ({acc_q, sh_q} != 32'd0) begin
              hp_d    = {acc_q, sh_q};
              valid_d = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end else begin
            acc_d = {acc_q[15:0], sh_q};
            idx_d = idx_q + 2'd1;
          end
        end
        P_MASK: begin
          mask_d    = sh_q;
          valid_d   = 1'b1;
          p_state_d = P_IDLE;
        end
        default: p_state_d = P_IDLE;
      endcase
    end else if (rx_err) begin
      err_d     = 1'b1;
      p_state_d = P_IDLE;
      tmo_d     = '0;
    end else if (p_state_q != P_IDLE && tmo_q == TMO_END) begin
      err_d     = 1'b1;
      p_state_d = P_IDLE;
      tmo_d     = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      sh_q       <= '0;
`ifdef BLINK_CMD_PARITY_EN
      par_bad_q  <= 1'b0;
`endif
      p_state_q  <= P_IDLE;
      idx_q      <= '0;
      acc_q      <= '0;
      tmo_q      <= '0;
      hp_q       <= HP_RST;
      mask_q     <= MASK_RST;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      sync1_q    <= uart_rx;
      sync2_q    <= sync1_q;
      rx_prev_q  <= sync2_q;
      rx_state_q <= rx_state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      sh_q       <= sh_d;
`ifdef BLINK_CMD_PARITY_EN
      par_bad_q  <= par_bad_d;
`endif
      p_state_q  <= p_state_d;
      idx_q      <= idx_d;
      acc_q      <= acc_d;
      tmo_q      <= tmo_d;
      hp_q       <= hp_d;
      mask_q     <= mask_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  assign half_period = hp_q;
  assign led_mask    = mask_q;
  assign cmd_valid   = valid_q;
  assign cmd_err     = err_q;

endmodule

// File: tb/tb_blink_cmd_uart_rx.sv
// Scoreboard bench for blink_cmd_uart_rx (honours BLINK_CMD_PARITY_EN when defined).
module tb_blink_cmd_uart_rx;

  localparam int unsigned CPB = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        uart_rx = 1'b1;
  logic [31:0] half_period;
  logic [7:0]  led_mask;
  logic        cmd_valid;
  logic        cmd_err;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  typedef struct packed {
    logic        is_err;
    logic [31:0] hp;
    logic [7:0]  mask;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  blink_cmd_uart_rx #(
    .CLK_FREQ     (1_000_000),
    .BAUD         (100_000),
    .TIMEOUT_CLKS (500)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .uart_rx     (uart_rx),
    .half_period (half_period),
    .led_mask    (led_mask),
    .cmd_valid   (cmd_valid),
    .cmd_err     (cmd_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      if (cmd_valid && cmd_err) begin
        n_vec++;
        n_bad++;
        $display("FAIL pulse_overlap: cmd_valid=1 cmd_err=1, required never both");
      end else if (cmd_valid || cmd_err) begin
        n_vec++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_pulse: valid=%0b err=%0b at %0t, required no pulse",
                   cmd_valid, cmd_err, $time);
        end else begin
          mon_e = sb.pop_front();
          if (mon_e.is_err != cmd_err || half_period != mon_e.hp || led_mask != mon_e.mask) begin
            n_bad++;
            $display("FAIL event: got err=%0b hp=%0d mask=%02h, required err=%0b hp=%0d mask=%02h",
                     cmd_err, half_period, led_mask, mon_e.is_err, mon_e.hp, mon_e.mask);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic expect_ev(input logic is_err, input logic [31:0] hp, input logic [7:0] mask);
    exp_t e;
    e.is_err = is_err;
    e.hp     = hp;
    e.mask   = mask;
    sb.push_back(e);
  endtask

  task automatic wait_drain(input string name, input int unsigned budget);
    int unsigned k = 0;
    while (sb.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    n_vec++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL %s: %0d expected events never seen, required 0 pending", name, sb.size());
      sb.delete();
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
`ifdef BLINK_CMD_PARITY_EN
    uart_rx = ^b;
    repeat (CPB) @(negedge clk);
`endif
    uart_rx = stop;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
  endtask

`ifdef BLINK_CMD_PARITY_EN
  task automatic send_byte_badpar(input logic [7:0] b);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = ~(^b);
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
    repeat (CPB + 3) @(negedge clk);
  endtask
`endif

  initial begin
    repeat (5) @(negedge clk);
    chk("rst_half_period", half_period, 32'd100_000);
    chk("rst_led_mask", {24'd0, led_mask}, 32'h01);
    chk("rst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
    chk("rst_cmd_err", {31'd0, cmd_err}, 32'd0);
    rst_n = 1'b1;
    repeat (1000) @(negedge clk);
    chk("idle_half_period", half_period, 32'd100_000);

    // period command 500, no partial update before the 4th byte
    send_byte(8'h50, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1);
    chk("no_partial_period", half_period, 32'd100_000);
    expect_ev(1'b0, 32'd500, 8'h01);
    send_byte(8'hF4, 1'b1);
    wait_drain("period_500", 50);
    chk("period_500_held", half_period, 32'd500);

    expect_ev(1'b0, 32'd500, 8'hA5);
    send_byte(8'h4D, 1'b1);
    send_byte(8'hA5, 1'b1);
    wait_drain("mask_a5", 50);

    expect_ev(1'b0, 32'd100_000, 8'h01);
    send_byte(8'h52, 1'b1);
    wait_drain("restore", 50);

    // timeout: no pulse for 400 clks, then an error before 600
    send_byte(8'h50, 1'b1);
    send_byte(8'h00, 1'b1);
    repeat (400) @(negedge clk);
    expect_ev(1'b1, 32'd100_000, 8'h01);
    wait_drain("timeout", 200);

    expect_ev(1'b0, 32'd100_000, 8'h0F);
    send_byte(8'h4D, 1'b1);
    send_byte(8'h0F, 1'b1);
    wait_drain("mask_after_timeout", 50);

    // framing error: stop bit low, line held low a while (break)
    expect_ev(1'b1, 32'd100_000, 8'h0F);
    send_byte(8'h50, 1'b0);
    wait_drain("framing_err", 50);
    chk("frame_hp_kept", half_period, 32'd100_000);
    chk("frame_mask_kept", {24'd0, led_mask}, 32'h0F);

    uart_rx = 1'b0;
    repeat (3) @(negedge clk);
    uart_rx = 1'b1;
    repeat (50) @(negedge clk);
    chk("glitch_mask_kept", {24'd0, led_mask}, 32'h0F);

    expect_ev(1'b0, 32'd100_000, 8'h00);
    send_byte(8'h4D, 1'b1);
    send_byte(8'h00, 1'b1);
    wait_drain("mask_zero", 50);

    expect_ev(1'b1, 32'd100_000, 8'h00);
    send_byte(8'h50, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    wait_drain("zero_period", 50);
    chk("zero_hp_kept", half_period, 32'd100_000);

    expect_ev(1'b0, 32'h12345678, 8'h00);
    send_byte(8'h50, 1'b1);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'h56, 1'b1);
    send_byte(8'h78, 1'b1);
    wait_drain("period_big_endian", 50);

`ifdef BLINK_CMD_PARITY_EN
    expect_ev(1'b1, 32'h12345678, 8'h00);
    send_byte(8'h4D, 1'b1);
    send_byte_badpar(8'h3C);
    wait_drain("parity_err", 50);
    chk("parity_mask_kept", {24'd0, led_mask}, 32'h00);
    expect_ev(1'b0, 32'h12345678, 8'h3C);
    send_byte(8'h4D, 1'b1);
    send_byte(8'h3C, 1'b1);
    wait_drain("parity_good", 50);
`endif

    repeat (50) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/blink_cmd_uart_rx.md
Name: blink_cmd_uart_rx

Overview:
- UART command receiver that sits directly upstream of the LED blinker stage.
- Deserialises 8N1 bytes from the remote-control serial line and parses short command frames.
- Holds the blinker configuration registers: toggle half-period in clocks, and the 8-bit LED enable mask.
- The blinker consumes half_period and led_mask continuously as static configuration.

Parameters:
- CLK_FREQ, 25_000_000, system clock frequency in Hz.
- BAUD, 115_200, serial bit rate. Derived localparam CLKS_PER_BIT = CLK_FREQ/BAUD, integer division, truncated.
- TIMEOUT_CLKS, CLK_FREQ/100, maximum idle clocks allowed between bytes of one command before it is aborted.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- uart_rx  in  1  serial input. Idle high. Asynchronous to clk.
- half_period  out  32  blinker toggle interval in clocks.
- led_mask  out  8  LEDs the blinker may drive.
- cmd_valid  out  1  one-cycle pulse on each accepted command.
- cmd_err  out  1  one-cycle pulse on a framing error, parity error, zero period or timeout.

Behaviour:
- Reset is asynchronous and active-low. Every state bit clears. Output reset values: half_period = CLK_FREQ/10, led_mask = 8'h01, cmd_valid = 0, cmd_err = 0.
- uart_rx passes through a 2-FF synchroniser; the synchroniser resets to 1. All RX logic uses the synchronised signal.
- RX FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE -> START on a synchronised high-to-low transition.
  - START: sample at CLKS_PER_BIT/2. If the line is high, treat it as a glitch and return to IDLE with no error. Otherwise go to DATA.
  - DATA: sample 8 bits LSB first, each CLKS_PER_BIT after the previous sample.
  - STOP: sample one CLKS_PER_BIT later. High means a byte is accepted and the FSM returns to IDLE. Low means cmd_err pulses, the byte is dropped and the FSM enters BREAK.
  - BREAK waits for the line to go high, then returns to IDLE.
- Parser FSM states: P_IDLE, P_PERIOD (byte index 0..3), P_MASK.
- Parser in P_IDLE:
  - 0x50 'P' -> P_PERIOD, index 0.
  - 0x4D 'M' -> P_MASK.
  - 0x52 'R' -> restore reset values of half_period and led_mask; cmd_valid pulses.
  - Any other byte is ignored silently.
- P_PERIOD: collects 4 bytes, big-endian. On the 4th byte:
  - Nonzero value: half_period loads it, cmd_valid pulses.
  - Zero: half_period is unchanged and cmd_err pulses.
  - Either way the parser returns to P_IDLE.
- P_MASK: the next byte loads led_mask, cmd_valid pulses, parser returns to P_IDLE. Mask 0x00 is legal.
- Latency: registers update and cmd_valid asserts exactly 1 clk after the stop-bit sample of the final byte.
- Partial updates never occur. half_period changes only after all 4 bytes arrive.
- Timeout: a counter clears on each accepted byte and counts while the parser is not in P_IDLE. When it reaches TIMEOUT_CLKS, the parser goes to P_IDLE, cmd_err pulses and the partial data is discarded.
- A framing error while the parser is not in P_IDLE also aborts it to P_IDLE. Only one cmd_err pulse is issued for that event.
- cmd_valid and cmd_err are never asserted in the same cycle.
- Reset mid-byte or mid-command discards everything. The first valid start bit after reset release is received normally.

Optional Feature:
- Macro: BLINK_CMD_PARITY_EN.
- When defined, the frame is 8E1: an even-parity bit follows D7 and precedes stop. On mismatch the byte is dropped, cmd_err pulses and the parser aborts to P_IDLE.
- When undefined, the frame is 8N1 and there is no parity logic.

Test Plan (CLK_FREQ=1_000_000, BAUD=100_000, so 10 clks/bit; TIMEOUT_CLKS=500):
- Reset -> half_period=100_000, led_mask=0x01, both pulses low; line held idle for 1000 clks -> no pulses.
- Send 'P',0x00,0x00,0x01,0xF4 -> half_period=500 one clk after the last stop sample; a single cmd_valid pulse.
- Send 'M',0xA5 -> led_mask=0xA5 with one cmd_valid pulse; then send 'R' -> half_period=100_000, led_mask=0x01.
- Send 'P',0x00 then idle 600 clks -> cmd_err pulse at 500 clks after the last byte; a following 'M',0x0F still gives led_mask=0x0F.
- Send 'P' with its stop bit forced low -> cmd_err pulse and no register change; a 3-clk low glitch on uart_rx -> no byte and no pulses.
- Send 'P',0,0,0,0 -> cmd_err pulse, half_period unchanged. With BLINK_CMD_PARITY_EN, send 'M' with a wrong parity bit -> cmd_err pulse and led_mask unchanged.
